// File: rtl/buck_pkg.sv
// Shared definitions for the buck-converter ADC sequencing path: data width,
// sequencer state encoding and default timing constants.
package buck_pkg;

  localparam int ADC_DW           = 8;
  localparam int CONV_LOW_DEF     = 2;
  localparam int BUSY_TIMEOUT_DEF = 40;
  localparam int RD_CYCLES_DEF    = 2;
  localparam int FAULT_LIMIT_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    WAIT = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// ADC-side and sample-side signals of the conversion sequencer, bundled with
// a slave modport for the sequencer and a master modport for whoever drives it.
interface adc_conv_sequencer_if #(
  parameter int DW = buck_pkg::ADC_DW
);

  logic          i_trig;
  logic          i_adc_busy;
  logic [DW-1:0] i_datain;
  logic          i_clr_fault;
  logic          o_convst_bar;
  logic          o_rd_bar;
  logic [DW-1:0] o_sample;
  logic          o_sample_valid;
  logic          o_overrun;
  logic          o_adc_fault;
  logic          o_pwm_en;

  modport slave (
    input  i_trig, i_adc_busy, i_datain, i_clr_fault,
    output o_convst_bar, o_rd_bar, o_sample, o_sample_valid,
           o_overrun, o_adc_fault, o_pwm_en
  );

  modport master (
    output i_trig, i_adc_busy, i_datain, i_clr_fault,
    input  o_convst_bar, o_rd_bar, o_sample, o_sample_valid,
           o_overrun, o_adc_fault, o_pwm_en
  );

endinterface

// File: rtl/adc_conv_sequencer_seq_timer.sv
// Loadable down-counter with a terminal-count flag; one instance paces the
// CONV, WAIT and READ phases of the sequencer in turn.
module seq_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule

// File: rtl/adc_conv_sequencer.sv
// Per-period ADC conversion sequencer with busy timeout, fault/overrun supervision
// and power-stage gating. Define DOUBLE_SAMPLE_EN to average two conversions per trig.
module adc_conv_sequencer
  import buck_pkg::*;
#(
  parameter int DW           = ADC_DW,
  parameter int CONV_LOW     = CONV_LOW_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int RD_CYCLES    = RD_CYCLES_DEF,
  parameter int FAULT_LIMIT  = FAULT_LIMIT_DEF
) (
  input logic                clk,
  input logic                rst_n,
  adc_conv_sequencer_if.slave bus
);

  localparam int TMAX = maxOf3(CONV_LOW, BUSY_TIMEOUT, RD_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int WCW  = $clog2(BUSY_TIMEOUT);
  localparam int FCW  = $clog2(FAULT_LIMIT + 1);

  seq_state_t    r_state;
  logic          r_convstBar;
  logic          r_rdBar;
  logic          r_sampleValid;
  logic          r_overrun;
  logic          r_adcFault;
  logic          r_pwmEn;
  logic [DW-1:0] r_sample;
  logic [DW-1:0] r_shadow0;
  logic [FCW-1:0] r_faultCnt;
`ifdef DOUBLE_SAMPLE_EN
  logic          r_pass;
  logic [DW-1:0] r_shadow1;
  logic [DW:0]   w_sum;
`endif

  logic           w_timerLoad;
  logic [TW-1:0]  w_timerVal;
  logic [TW-1:0]  w_timerCnt;
  logic           w_tc;
  logic [WCW-1:0] w_wcnt;
  logic           w_goRead;
  logic           w_timeout;
  logic           w_done;
  logic [FCW-1:0] w_faultCntNext;
  logic           w_faultNext;

  seq_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_timerLoad),
    .i_loadVal (w_timerVal),
    .o_count   (w_timerCnt),
    .o_tc      (w_tc)
  );

  // The timer counts down through WAIT, so elapsed wait cycles are its distance from the load value.
  assign w_wcnt    = WCW'(TW'(BUSY_TIMEOUT - 1) - w_timerCnt);
  assign w_goRead  = (r_state == WAIT) && (w_wcnt != '0) && !bus.i_adc_busy;
  assign w_timeout = (r_state == WAIT) && w_tc && bus.i_adc_busy;
  assign w_done    = (r_state == DONE);
`ifdef DOUBLE_SAMPLE_EN
  assign w_sum     = {1'b0, r_shadow0} + {1'b0, r_shadow1} + (DW+1)'(1);
`endif

  always_comb begin
    w_timerLoad = 1'b0;
    w_timerVal  = TW'(CONV_LOW - 1);
    case (r_state)
      IDLE: w_timerLoad = 1'b1;
      CONV: if (w_tc) begin
        w_timerLoad = 1'b1;
        w_timerVal  = TW'(BUSY_TIMEOUT - 1);
      end
      WAIT: if (w_goRead) begin
        w_timerLoad = 1'b1;
        w_timerVal  = TW'(RD_CYCLES - 1);
      end
      READ: w_timerLoad = w_tc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_convstBar   <= 1'b1;
      r_rdBar       <= 1'b1;
      r_sample      <= '0;
      r_sampleValid <= 1'b0;
      r_shadow0     <= '0;
`ifdef DOUBLE_SAMPLE_EN
      r_pass        <= 1'b0;
      r_shadow1     <= '0;
`endif
    end else begin
      r_sampleValid <= 1'b0;
      case (r_state)
        IDLE: if (bus.i_trig) begin
          r_state     <= CONV;
          r_convstBar <= 1'b0;
`ifdef DOUBLE_SAMPLE_EN
          r_pass      <= 1'b0;
`endif
        end
        CONV: if (w_tc) begin
          r_state     <= WAIT;
          r_convstBar <= 1'b1;
        end
        WAIT: if (w_goRead) begin
          r_state <= READ;
          r_rdBar <= 1'b0;
        end else if (w_timeout) begin
          r_state <= IDLE;
        end
        READ: if (w_tc) begin
          r_rdBar <= 1'b1;
`ifdef DOUBLE_SAMPLE_EN
          if (!r_pass) begin
            r_shadow0   <= bus.i_datain;
            r_pass      <= 1'b1;
            r_state     <= CONV;
            r_convstBar <= 1'b0;
          end else begin
            r_shadow1 <= bus.i_datain;
            r_state   <= DONE;
          end
`else
          r_shadow0 <= bus.i_datain;
          r_state   <= DONE;
`endif
        end
        DONE: begin
`ifdef DOUBLE_SAMPLE_EN
          r_sample <= w_sum[DW:1];
`else
          r_sample <= r_shadow0;
`endif
          r_sampleValid <= 1'b1;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A clear lands first, so a timeout in the same cycle counts as the first fault after it.
  always_comb begin
    w_faultCntNext = bus.i_clr_fault ? '0 : r_faultCnt;
    if (w_timeout) begin
      if (w_faultCntNext != FCW'(FAULT_LIMIT)) begin
        w_faultCntNext = w_faultCntNext + FCW'(1);
      end
    end else if (w_done) begin
      w_faultCntNext = '0;
    end
    w_faultNext = (r_adcFault && !bus.i_clr_fault) ||
                  (w_faultCntNext == FCW'(FAULT_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_faultCnt <= '0;
      r_adcFault <= 1'b0;
      r_overrun  <= 1'b0;
      r_pwmEn    <= 1'b0;
    end else begin
      r_faultCnt <= w_faultCntNext;
      r_adcFault <= w_faultNext;
      r_overrun  <= (r_overrun && !bus.i_clr_fault) ||
                    (bus.i_trig && (r_state != IDLE));
      if (w_faultNext) begin
        r_pwmEn <= 1'b0;
      end else if (w_done) begin
        r_pwmEn <= 1'b1;
      end else if (bus.i_clr_fault) begin
        r_pwmEn <= 1'b0;
      end
    end
  end

  assign bus.o_convst_bar   = r_convstBar;
  assign bus.o_rd_bar       = r_rdBar;
  assign bus.o_sample       = r_sample;
  assign bus.o_sample_valid = r_sampleValid;
  assign bus.o_overrun      = r_overrun;
  assign bus.o_adc_fault    = r_adcFault;
  assign bus.o_pwm_en       = r_pwmEn;

endmodule
